// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_rx_pkg;

   localparam int unsigned DEF_OVERSAMPLE = 4;
   localparam int unsigned DEF_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial line in, parallel word plus status out.
interface serial_frame_receiver_if #(
   parameter int unsigned DATA_BITS = serial_rx_pkg::DEF_DATA_BITS
);

   logic                 din;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   // Upstream line driver / downstream consumer side
   modport master (
      output din,
      input  data_out, data_valid, parity_err, frame_err, busy
   );

   // Receiver side
   modport slave (
      input  din,
      output data_out, data_valid, parity_err, frame_err, busy
   );

endinterface

// File: rtl/serial_frame_receiver_bit_timer.sv
// Down-counting bit timer; reloads OVERSAMPLE-1 on expiry, expire is registered.
module bit_timer
   import serial_rx_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned TMR_W      = $clog2(OVERSAMPLE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_value,
   output logic             expire
);

   logic [TMR_W-1:0] r_count;
   logic [TMR_W-1:0] w_count_next;
   logic             r_expire;

   // Expire is precomputed from the next count so it lines up with count==0
   always_comb begin
      w_count_next = r_count - TMR_W'(1);
      if (load) begin
         w_count_next = load_value;
      end else if (r_count == '0) begin
         w_count_next = TMR_W'(OVERSAMPLE - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_expire <= 1'b0;
      end else begin
         r_count  <= w_count_next;
         r_expire <= (w_count_next == '0);
      end
   end

   assign expire = r_expire;

endmodule

// File: rtl/serial_frame_receiver.sv
// Oversampled serial frame receiver: start, LSB-first data, optional even parity, stop.
module serial_frame_receiver
   import serial_rx_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned PARITY_EN  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_frame_receiver_if.slave  bus
);

   localparam int unsigned TMR_W = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(OVERSAMPLE - 1);

   rx_state_t            r_state;
   rx_state_t            w_state_next;
   logic                 w_timer_load;
   logic [TMR_W-1:0]     w_timer_value;
   logic                 w_expire;
   logic                 w_din;
   logic                 w_last_bit;

   logic [DATA_BITS-1:0] r_shift;
   logic [IDX_W-1:0]     r_bit_idx;
   logic                 r_parity;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_data_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_busy;

   assign w_din      = bus.din;
   assign w_last_bit = (r_bit_idx == IDX_W'(DATA_BITS - 1));

   bit_timer #(
      .OVERSAMPLE (OVERSAMPLE),
      .TMR_W      (TMR_W)
   ) u_bit_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (w_timer_load),
      .load_value (w_timer_value),
      .expire     (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and timer control
   always_comb begin
      w_state_next  = r_state;
      w_timer_load  = 1'b0;
      w_timer_value = FULL_LOAD;
      case (r_state)
         IDLE: begin
            if (!w_din) begin
               w_state_next  = START;
               w_timer_load  = 1'b1;
               w_timer_value = HALF_LOAD;
            end
         end
         START: begin
            if (w_expire) begin
               w_state_next = w_din ? IDLE : DATA;
               w_timer_load = 1'b1;
            end
         end
         DATA: begin
            if (w_expire && w_last_bit) begin
               w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (w_expire) begin
               w_state_next = STOP;
            end
         end
         STOP: begin
            if (w_expire) begin
               w_state_next = w_din ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (w_din) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Shift register, parity accumulator and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift      <= '0;
         r_bit_idx    <= '0;
         r_parity     <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_busy       <= (w_state_next != IDLE);
         case (r_state)
            START: begin
               if (w_expire && !w_din) begin
                  r_bit_idx <= '0;
                  r_parity  <= 1'b0;
               end
            end
            DATA: begin
               if (w_expire) begin
                  r_shift   <= {w_din, r_shift[DATA_BITS-1:1]};
                  r_bit_idx <= r_bit_idx + IDX_W'(1);
                  r_parity  <= r_parity ^ w_din;
               end
            end
            PARITY: begin
               if (w_expire) begin
                  r_parity <= r_parity ^ w_din;
               end
            end
            STOP: begin
               if (w_expire) begin
                  r_data_out   <= r_shift;
                  r_data_valid <= 1'b1;
                  r_parity_err <= (PARITY_EN != 0) ? r_parity : 1'b0;
                  r_frame_err  <= ~w_din;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_data_valid;
   assign bus.parity_err = r_parity_err;
   assign bus.frame_err  = r_frame_err;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver at defaults (OVERSAMPLE=4, 8 data bits, even parity).
module tb_serial_frame_receiver;

   localparam int unsigned OS = 4;
   localparam int unsigned DB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic rst_q = 1'b1;

   serial_frame_receiver_if #(.DATA_BITS(DB)) bus_if ();

   serial_frame_receiver #(
      .OVERSAMPLE (OS),
      .DATA_BITS  (DB),
      .PARITY_EN  (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   typedef struct {
      int         at;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } cap_t;

   cap_t       capq[$];
   logic [7:0] prev_data;
   logic       prev_pe, prev_fe, prev_valid;

   // Capture every data_valid pulse; outputs may only move with data_valid, pulse is one cycle
   always @(negedge clk) begin
      if (!rst_q) begin
         checks++;
         if (bus_if.data_valid ? (prev_valid === 1'b1)
                               : ((bus_if.data_out !== prev_data) || (bus_if.parity_err !== prev_pe) ||
                                  (bus_if.frame_err !== prev_fe))) begin
            errors++;
            $display("FAIL hold_or_pulse @cyc %0d: valid=%b data=0x%0h pe=%b fe=%b prev valid=%b data=0x%0h pe=%b fe=%b",
                     cyc, bus_if.data_valid, bus_if.data_out, bus_if.parity_err, bus_if.frame_err,
                     prev_valid, prev_data, prev_pe, prev_fe);
         end
         if (bus_if.data_valid === 1'b1) begin
            capq.push_back('{cyc + 1, bus_if.data_out, bus_if.parity_err, bus_if.frame_err});
         end
      end
      prev_data  = bus_if.data_out;
      prev_pe    = bus_if.parity_err;
      prev_fe    = bus_if.frame_err;
      prev_valid = bus_if.data_valid;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      bus_if.din = b;
      tick(n);
   endtask

   // t is the edge that first samples the start bit
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int stop_len, output int t);
      t = cyc + 1;
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
      drive_bit(p, OS);
      drive_bit(s, stop_len);
   endtask

   task automatic pop_check(input string name, input int t, input logic [7:0] d,
                            input logic pe, input logic fe);
      cap_t c;
      if (capq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_missing: got no data_valid, want one at cycle %0d", name, t + 43);
      end else begin
         c = capq.pop_front();
         chk({name, "_at"},   32'(c.at),   32'(t + 43));
         chk({name, "_data"}, 32'(c.data), 32'(d));
         chk({name, "_perr"}, 32'(c.perr), 32'(pe));
         chk({name, "_ferr"}, 32'(c.ferr), 32'(fe));
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int t, t1, t2;

      vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 1'b0, 8'h80, 1'b1, 1'b0};
      vecs[4] = '{8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0};

      bus_if.din = 1'b1;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_data_out",   32'(bus_if.data_out),   32'h0);
      chk("rst_data_valid", 32'(bus_if.data_valid), 32'h0);
      chk("rst_parity_err", 32'(bus_if.parity_err), 32'h0);
      chk("rst_frame_err",  32'(bus_if.frame_err),  32'h0);
      chk("rst_busy",       32'(bus_if.busy),       32'h0);

      tick(200);
      chk("idle_no_valid", 32'(capq.size()), 32'h0);
      chk("idle_busy",     32'(bus_if.busy), 32'h0);

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].data, vecs[i].par, 1'b1, OS, t);
         chk($sformatf("vec%0d_count", i), 32'(capq.size()), 32'h1);
         pop_check($sformatf("vec%0d", i), t, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
         chk($sformatf("vec%0d_busy", i), 32'(bus_if.busy), 32'h0);
      end

      // Next start bit sampled in the first IDLE cycle after the stop sample
      send_frame(8'hA5, 1'b0, 1'b1, OS - 1, t1);
      send_frame(8'h96, 1'b0, 1'b1, OS, t2);
      chk("b2b_count", 32'(capq.size()), 32'h2);
      pop_check("b2b_first", t1, 8'hA5, 1'b0, 1'b0);
      pop_check("b2b_second", t2, 8'h96, 1'b0, 1'b0);

      // Two-cycle glitch rejected at the mid-bit start check
      bus_if.din = 1'b0;
      @(negedge clk);
      chk("glitch_busy0", 32'(bus_if.busy), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("glitch_busy1", 32'(bus_if.busy), 32'h1);
      @(posedge clk); #1;
      bus_if.din = 1'b1;
      @(negedge clk);
      chk("glitch_busy2", 32'(bus_if.busy), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("glitch_busy3", 32'(bus_if.busy), 32'h0);
      @(posedge clk); #1;
      tick(10);
      chk("glitch_no_valid", 32'(capq.size()), 32'h0);

      // Stop bit 0, line held low, no restart until it returns high
      send_frame(8'h0F, 1'b0, 1'b0, OS, t);
      pop_check("ferr", t, 8'h0F, 1'b0, 1'b1);
      drive_bit(1'b0, 16);
      chk("ferr_low_busy",     32'(bus_if.busy),  32'h1);
      chk("ferr_low_no_valid", 32'(capq.size()), 32'h0);
      drive_bit(1'b1, 2);
      chk("ferr_release_busy", 32'(bus_if.busy), 32'h0);
      send_frame(8'h55, 1'b0, 1'b1, OS, t);
      pop_check("after_ferr", t, 8'h55, 1'b0, 1'b0);

      // Reset pulse at t+20 inside a frame of 0xFF
      t = cyc + 1;
      drive_bit(1'b0, OS);
      drive_bit(1'b1, 16);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_busy_now", 32'(bus_if.busy), 32'h0);
      tick(60);
      chk("midrst_no_valid", 32'(capq.size()),     32'h0);
      chk("midrst_busy",     32'(bus_if.busy),     32'h0);
      chk("midrst_data_out", 32'(bus_if.data_out), 32'h0);
      send_frame(8'h81, 1'b0, 1'b1, OS, t);
      pop_check("after_rst", t, 8'h81, 1'b0, 1'b0);
      tick(5);
      chk("final_no_extra", 32'(capq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
